// File: rtl/mac_array_ctrl_pkg.sv
// Shared encodings and FSM state type for the systolic MAC array controller.
package mac_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_LOAD = 3'd3,
    ST_EXEC      = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_DONE      = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Job / L0 / ofifo / array control bundle between the core FSM side and the controller.
interface mac_array_ctrl_if #(
  parameter int cnt_bw = 8
) ();

  logic              start;
  logic              mode_in;
  logic [cnt_bw-1:0] num_vec;
  logic              l0_empty;
  logic              ofifo_full;
  logic              l0_rd;
  logic [1:0]        inst_w;
  logic              mode_select;
  logic              array_reset;
  logic              psum_wr;
  logic              busy;
  logic              done;

  modport master (
    output start, mode_in, num_vec, l0_empty, ofifo_full,
    input  l0_rd, inst_w, mode_select, array_reset, psum_wr, busy, done
  );

  modport slave (
    input  start, mode_in, num_vec, l0_empty, ofifo_full,
    output l0_rd, inst_w, mode_select, array_reset, psum_wr, busy, done
  );

endinterface

// File: rtl/mac_array_ctrl_psum_valid_pipe.sv
// Tracks issued execute beats through the array so psum_wr fires when each reaches the south edge.
module psum_valid_pipe #(
  parameter int depth = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic in_flight
);

  logic [depth-1:0] sr_r;

  // Shift one stage per cycle; synchronous clear drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_r <= '0;
    end else begin
      sr_r <= {sr_r[depth-2:0], din};
    end
  end

  // Beats in the last two stages are emitted by the time DONE is reached, so they do not hold DRAIN.
  always_comb begin
    in_flight = din;
    for (int i = 0; i < depth - 2; i++) begin
      in_flight = in_flight | sr_r[i];
    end
  end

  assign dout = sr_r[depth-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequences clear, kernel load, weight settle, throttled activation issue and psum drain for the MAC array.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input logic             clk,
  input logic             reset,
  mac_array_ctrl_if.slave bus
);

  localparam int              lc_bw    = $clog2(col + 1);
  localparam logic [lc_bw-1:0] col_last = lc_bw'(col - 1);

  ctrl_state_e       state_r, state_s;
  logic              mode_r, mode_s;
  logic [cnt_bw-1:0] num_vec_r, num_vec_s;
  logic [cnt_bw-1:0] vec_cnt_r, vec_cnt_s;
  logic [lc_bw-1:0]  load_cnt_r, load_cnt_s;
  logic [lc_bw-1:0]  wait_cnt_r, wait_cnt_s;
  logic              l0_rd_s;
  logic [1:0]        inst_w_s;
  logic              in_flight_s;
  logic              psum_wr_s;

  logic              l0_rd_r;
  logic [1:0]        inst_w_r;
  logic              mode_select_r;
  logic              array_reset_r;
  logic              busy_r;
  logic              done_r;

  // State, job latch and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_WS;
      num_vec_r  <= '0;
      vec_cnt_r  <= '0;
      load_cnt_r <= '0;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      mode_r     <= mode_s;
      num_vec_r  <= num_vec_s;
      vec_cnt_r  <= vec_cnt_s;
      load_cnt_r <= load_cnt_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Next-state, counter and array-command decode.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    num_vec_s  = num_vec_r;
    vec_cnt_s  = vec_cnt_r;
    load_cnt_s = load_cnt_r;
    wait_cnt_s = wait_cnt_r;
    l0_rd_s    = 1'b0;
    inst_w_s   = INST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          mode_s     = bus.mode_in;
          num_vec_s  = bus.num_vec;
          vec_cnt_s  = '0;
          load_cnt_s = '0;
          wait_cnt_s = '0;
          state_s    = ST_CLR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (mode_r == MODE_WS) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_LOAD: begin
        if (!bus.l0_empty && (load_cnt_r <= col_last)) begin
          l0_rd_s    = 1'b1;
          inst_w_s   = INST_LOAD;
          load_cnt_s = load_cnt_r + lc_bw'(1);
          if (load_cnt_r == col_last) begin
            state_s = ST_WAIT_LOAD;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WAIT_LOAD: begin
        if (wait_cnt_r < col_last) begin
          wait_cnt_s = wait_cnt_r + lc_bw'(1);
          state_s    = ST_WAIT_LOAD;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (vec_cnt_r >= num_vec_r) begin
          state_s = ST_DRAIN;
        end else if (!bus.l0_empty && !bus.ofifo_full) begin
          l0_rd_s   = 1'b1;
          inst_w_s  = INST_EXEC;
          vec_cnt_s = vec_cnt_r + cnt_bw'(1);
          if ((vec_cnt_r + cnt_bw'(1)) == num_vec_r) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_DRAIN: begin
        if (!in_flight_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output registers, all derived from the state present at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      l0_rd_r       <= 1'b0;
      inst_w_r      <= INST_IDLE;
      mode_select_r <= 1'b0;
      array_reset_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      l0_rd_r       <= l0_rd_s;
      inst_w_r      <= inst_w_s;
      mode_select_r <= mode_r;
      array_reset_r <= (state_r == ST_CLR);
      busy_r        <= (state_r != ST_IDLE);
      done_r        <= (state_r == ST_DONE);
    end
  end

  psum_valid_pipe #(
    .depth(row)
  ) u_psum_pipe (
    .clk      (clk),
    .clr      (reset),
    .din      (inst_w_r == INST_EXEC),
    .dout     (psum_wr_s),
    .in_flight(in_flight_s)
  );

  assign bus.l0_rd       = l0_rd_r;
  assign bus.inst_w      = inst_w_r;
  assign bus.mode_select = mode_select_r;
  assign bus.array_reset = array_reset_r;
  assign bus.psum_wr     = psum_wr_s;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench: a cycle model queues expected outputs per edge, compared one cycle-slot later.
module tb_mac_array_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;

  logic clk;
  logic reset;

  mac_array_ctrl_if #(.cnt_bw(8)) bus ();

  mac_array_ctrl #(
    .row   (ROW),
    .col   (COL),
    .cnt_bw(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];

  // model state: 0 idle, 1 clr, 2 load, 3 wait, 4 exec, 5 drain, 6 done
  int   m_st = 0;
  logic m_mode = 1'b0;
  int   m_nv = 0, m_lc = 0, m_wc = 0, m_vc = 0;
  int   due_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic md, input int nv,
                            input logic em, input logic fu, output logic [7:0] word);
    logic rd, ms, ar, ps, bz, dn;
    logic [1:0] inst;
    rd = 1'b0; inst = 2'b00; ps = 1'b0;
    if (rst) begin
      m_st = 0; m_mode = 1'b0; m_nv = 0; m_lc = 0; m_wc = 0; m_vc = 0;
      due_q.delete();
      word = 8'h00;
    end else begin
      ms = m_mode;
      ar = (m_st == 1);
      bz = (m_st != 0);
      dn = (m_st == 6);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        ps = 1'b1;
        void'(due_q.pop_front());
      end
      case (m_st)
        0: if (st) begin
             m_mode = md; m_nv = nv; m_lc = 0; m_wc = 0; m_vc = 0; m_st = 1;
           end
        1: m_st = m_mode ? 4 : 2;
        2: if (!em) begin
             rd = 1'b1; inst = 2'b01; m_lc++;
             if (m_lc == COL) m_st = 3;
           end
        3: begin
             m_wc++;
             if (m_wc == COL) m_st = 4;
           end
        4: begin
             if (m_vc < m_nv && !em && !fu) begin
               rd = 1'b1; inst = 2'b10; m_vc++;
               due_q.push_back(cyc + ROW);
             end
             if (m_vc >= m_nv) m_st = 5;
           end
        5: if (due_q.size() == 0) m_st = 6;
        default: m_st = 0;
      endcase
      word = {rd, inst, ms, ar, ps, bz, dn};
    end
  endtask

  int n_psum, n_load, n_done;

  task automatic tick(input logic rst, input logic st, input logic md, input int nv,
                      input logic em, input logic fu);
    logic [7:0] w, obs;
    reset          = rst;
    bus.start      = st;
    bus.mode_in    = md;
    bus.num_vec    = nv[7:0];
    bus.l0_empty   = em;
    bus.ofifo_full = fu;
    @(posedge clk);
    model_step(rst, st, md, nv, em, fu, w);
    exp_q.push_back(w);
    #1;
    obs = {bus.l0_rd, bus.inst_w, bus.mode_select, bus.array_reset, bus.psum_wr, bus.busy, bus.done};
    check_val($sformatf("outs@%0d", cyc), {24'h0, obs}, {24'h0, exp_q.pop_front()});
    n_psum += int'(bus.psum_wr);
    n_load += int'(bus.inst_w == 2'b01);
    n_done += int'(bus.done);
    cyc++;
  endtask

  // One job; windows are inclusive cycle ranges relative to the start cycle (k==0).
  task automatic run_job(input string name, input logic md, input int nv,
                         input int em_lo, input int em_hi, input int fu_lo, input int fu_hi,
                         input int s2_lo, input int s2_hi, input int rst_at,
                         input int exp_psum, input int exp_load, input int exp_done);
    int  k;
    bit  finished;
    n_psum = 0; n_load = 0; n_done = 0;
    finished = 1'b0;
    for (k = 0; k < 200; k++) begin
      tick(k == rst_at, (k == 0) || (k >= s2_lo && k <= s2_hi), md, nv,
           (k >= em_lo && k <= em_hi), (k >= fu_lo && k <= fu_hi));
      if (m_st == 0 && k > 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check_val({name, "_timeout"}, 32'd1, 32'd0);
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, md, nv, 1'b0, 1'b0);
    check_val({name, "_psum_cnt"}, n_psum, exp_psum);
    check_val({name, "_load_cnt"}, n_load, exp_load);
    check_val({name, "_done_cnt"}, n_done, exp_done);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0);

    run_job("ws4",     1'b0, 4,  -1, -1, -1, -1, -1, -1, -1, 4, 8, 1);
    run_job("os3",     1'b1, 3,  -1, -1, -1, -1, -1, -1, -1, 3, 0, 1);
    run_job("ws_l0gap",1'b0, 2,   4,  6, -1, -1, -1, -1, -1, 2, 8, 1);
    run_job("os_full", 1'b1, 6,  -1, -1,  4,  8, -1, -1, -1, 6, 0, 1);
    run_job("os_zero", 1'b1, 0,  -1, -1, -1, -1,  2,  3, -1, 0, 0, 1);
    run_job("abort",   1'b1, 10, -1, -1, -1, -1, -1, -1,  5, 0, 0, 0);
    run_job("restart", 1'b1, 2,  -1, -1, -1, -1, -1, -1, -1, 2, 0, 1);
    run_job("ws_full", 1'b0, 5,   3,  3, 20, 22, -1, -1, -1, 5, 8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
